arilla_bus_master: RTL and testbench
====================================

Name: arilla_bus_master

Overview:
- Controller-side bridge that turns core load/store requests (byte address, size, sign) into arilla bus word transactions.
- Sits directly upstream of the arilla bus interface and drives the controller-to-peripheral half: address, byte_enable, data_ctp, read, write.
- Consumes data_ptc, available, hit and intercept.
- Performs lane alignment, write-data replication, read extraction with sign/zero extension, and fault reporting.

Parameters:
- DataWidth, 32, bus data width; size decode supports exactly 32 (elaboration assertion).
- ByteAddressWidth, 32, request byte-address width.
- ByteSize, 8, bits per byte lane.
- TimeoutCycles, 1024, stall limit used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  ByteAddressWidth  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend load data.
- req_wdata  in  DataWidth  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DataWidth  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned, illegal size, no hit, or timeout.
- rsp_intercept  out  1  intercept was sampled high at completion.
- bus_address  out  ByteAddressWidth-2  word address, equal to req_address[ByteAddressWidth-1:2].
- bus_byte_enable  out  4  lane enables.
- bus_data_ctp  out  DataWidth  write data.
- bus_read  out  1  read strobe.
- bus_write  out  1  write strobe.
- bus_data_ptc  in  DataWidth  read data.
- bus_available  in  1  completion qualifier; pulled high, so a silent bus completes at once.
- bus_hit  in  1  some target decoded the address.
- bus_intercept  in  1  debug logic claimed the access.

Behaviour:
- FSM states: IDLE, BUS, RESP. All outputs come from registers.
- Reset: state = IDLE. All outputs 0, except req_ready = 1.
- Reset mid-transaction: bus_read/bus_write drop asynchronously, no rsp_valid is issued, the FSM restarts in IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all req_* fields.
  - Misaligned (half with addr[0] = 1; word with addr[1:0] != 0) or size 3: go to RESP with fault = 1. No bus activity.
  - Otherwise go to BUS.
- BUS:
  - req_ready = 0.
  - bus_read or bus_write = 1. Address, byte_enable and data_ctp are held stable every cycle in BUS.
  - Stay in BUS while bus_available = 0.
  - First cycle with bus_available = 1 completes the transfer: sample data_ptc, hit and intercept; go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - rsp_fault = !hit, or the alignment/size fault.
  - req_ready = 0 in RESP.
- Latency: accept at cycle N → bus strobe at N+1 → rsp_valid at N+2 + stall cycles. Faulted requests respond at N+1.
- Throughput: one request per 3 cycles maximum; no pipelining.
- Byte enables (off = addr[1:0]):
  - byte: 4'b0001 << off.
  - half: 4'b0011 << off.
  - word: 4'b1111.
- Write data replication:
  - byte: wdata[7:0] on all 4 lanes.
  - half: wdata[15:0] on both halves.
  - word: unchanged.
- Read data: data_ptc >> (8*off), then truncate to the size and sign- or zero-extend per req_unsigned.
- Idle bus values: bus_read = bus_write = 0, byte_enable = 0, data_ctp = 0. Address keeps its last value.
- Stores return rsp_rdata = 0.
- rsp_intercept and rsp_fault are independent. An intercepted access with hit = 0 reports both.
- req_ready deasserts the cycle after acceptance; the core must not depend on combinational ready.

Optional Feature:
- Macro: ARILLA_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A down-counter of width $clog2(TimeoutCycles+1) loads TimeoutCycles on entering BUS.
  - It decrements on every cycle with bus_available = 0.
  - On reaching 0 the access is aborted: strobes drop, go to RESP with rsp_fault = 1, rsp_rdata = 0.
  - If bus_available = 1 in the same cycle the counter hits 0, completion wins.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- Load byte, addr 0x1003, unsigned = 0, data_ptc = 0x80FF_0000, hit = 1, available = 1 → byte_enable = 4'b1000, bus_address = 0x400, rsp_rdata = 0xFFFF_FF80, rsp_valid at cycle N+2.
- Store half, addr 0x22, wdata = 0x1234_ABCD → byte_enable = 4'b1100, data_ctp = 0xABCD_ABCD, write held 3 extra cycles while available = 0, rsp_fault = 0.
- Load word, addr 0x5 → no bus strobe, rsp_valid at N+1, rsp_fault = 1, rsp_rdata = 0.
- Load word, hit = 0, intercept = 1 → rsp_fault = 1, rsp_intercept = 1.
- rst_n pulsed low while in BUS with available = 0 → bus_read falls without waiting for a clock, no rsp_valid, req_ready = 1 after release.
- With ARILLA_BUS_MASTER_TIMEOUT_EN and TimeoutCycles = 4, available held 0 → strobe for 4 cycles, then rsp_fault = 1; repeat with available = 1 on cycle 4 → normal completion.

Source files
------------

// File: rtl/arilla_bus_master.sv
// Load/store request to arilla bus word-transaction bridge: lane alignment, write replication,
// read extraction with sign/zero extension, fault reporting. Optional stall timeout: ARILLA_BUS_MASTER_TIMEOUT_EN.
module arilla_bus_master #(
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int ByteSize         = 8,
  parameter int TimeoutCycles    = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ByteAddressWidth-1:0] req_address,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [DataWidth-1:0]        req_wdata,
  output logic                        rsp_valid,
  output logic [DataWidth-1:0]        rsp_rdata,
  output logic                        rsp_fault,
  output logic                        rsp_intercept,
  output logic [ByteAddressWidth-3:0] bus_address,
  output logic [3:0]                  bus_byte_enable,
  output logic [DataWidth-1:0]        bus_data_ctp,
  output logic                        bus_read,
  output logic                        bus_write,
  input  logic [DataWidth-1:0]        bus_data_ptc,
  input  logic                        bus_available,
  input  logic                        bus_hit,
  input  logic                        bus_intercept,
  output logic [1:0]                  dbg_state
);

  if (DataWidth != 32 || ByteSize * 4 != DataWidth || TimeoutCycles < 1) begin : g_bad_cfg
    $error("arilla_bus_master: unsupported configuration");
  end

  // Request side: a request transfers on a clock edge where req_valid and req_ready are both high;
  // req_ready is registered and low from the cycle after acceptance until the response has gone out.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_e;

  state_e state_q, state_d;

  logic                        req_ready_q, req_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0]        rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_fault_q, rsp_fault_d;
  logic                        rsp_intercept_q, rsp_intercept_d;
  logic [ByteAddressWidth-3:0] bus_address_q, bus_address_d;
  logic [3:0]                  bus_byte_enable_q, bus_byte_enable_d;
  logic [DataWidth-1:0]        bus_data_ctp_q, bus_data_ctp_d;
  logic                        bus_read_q, bus_read_d;
  logic                        bus_write_q, bus_write_d;
  logic                        write_q, write_d;
  logic                        unsigned_q, unsigned_d;
  logic [1:0]                  size_q, size_d;
  logic [1:0]                  off_q, off_d;

`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]           req_off;
  logic                 req_misaligned;
  logic [3:0]           req_be;
  logic [DataWidth-1:0] req_wdata_rep;
  logic [DataWidth-1:0] rd_shifted;
  logic [DataWidth-1:0] rd_ext;

  always_comb begin
    req_off        = req_address[1:0];
    req_misaligned = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_off[0]) ||
                     (req_size == 2'd2 && req_off != 2'd0);
    case (req_size)
      2'd0:    req_be = 4'b0001 << req_off;
      2'd1:    req_be = 4'b0011 << req_off;
      default: req_be = 4'b1111;
    endcase
    case (req_size)
      2'd0:    req_wdata_rep = {4{req_wdata[ByteSize-1:0]}};
      2'd1:    req_wdata_rep = {2{req_wdata[2*ByteSize-1:0]}};
      default: req_wdata_rep = req_wdata;
    endcase
  end

  // Read data arrives lane-aligned; bring the addressed lane down to bit 0 before extending.
  always_comb begin
    rd_shifted = bus_data_ptc >> (int'(off_q) * ByteSize);
    case (size_q)
      2'd0:    rd_ext = {{(DataWidth-ByteSize){~unsigned_q & rd_shifted[ByteSize-1]}},
                         rd_shifted[ByteSize-1:0]};
      2'd1:    rd_ext = {{(DataWidth-2*ByteSize){~unsigned_q & rd_shifted[2*ByteSize-1]}},
                         rd_shifted[2*ByteSize-1:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    req_ready_d       = 1'b0;
    rsp_valid_d       = 1'b0;
    rsp_rdata_d       = rsp_rdata_q;
    rsp_fault_d       = rsp_fault_q;
    rsp_intercept_d   = rsp_intercept_q;
    bus_address_d     = bus_address_q;
    bus_byte_enable_d = bus_byte_enable_q;
    bus_data_ctp_d    = bus_data_ctp_q;
    bus_read_d        = bus_read_q;
    bus_write_d       = bus_write_q;
    write_d           = write_q;
    unsigned_d        = unsigned_q;
    size_d            = size_q;
    off_d             = off_q;
`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
    cnt_d             = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          write_d     = req_write;
          unsigned_d  = req_unsigned;
          size_d      = req_size;
          off_d       = req_off;
          if (req_misaligned) begin
            // Faulted requests never touch the bus, so the bus address keeps its old value.
            state_d         = RESP;
            rsp_valid_d     = 1'b1;
            rsp_fault_d     = 1'b1;
            rsp_intercept_d = 1'b0;
            rsp_rdata_d     = '0;
          end else begin
            state_d           = BUS;
            bus_address_d     = req_address[ByteAddressWidth-1:2];
            bus_byte_enable_d = req_be;
            bus_data_ctp_d    = req_write ? req_wdata_rep : '0;
            bus_read_d        = ~req_write;
            bus_write_d       = req_write;
`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
            cnt_d             = CntW'(TimeoutCycles);
`endif
          end
        end
      end

      BUS: begin
        if (bus_available) begin
          state_d           = RESP;
          rsp_valid_d       = 1'b1;
          rsp_fault_d       = ~bus_hit;
          rsp_intercept_d   = bus_intercept;
          rsp_rdata_d       = (write_q || !bus_hit) ? '0 : rd_ext;
          bus_byte_enable_d = 4'b0000;
          bus_data_ctp_d    = '0;
          bus_read_d        = 1'b0;
          bus_write_d       = 1'b0;
        end
`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
        else if (cnt_q <= CntW'(1)) begin
          state_d           = RESP;
          rsp_valid_d       = 1'b1;
          rsp_fault_d       = 1'b1;
          rsp_intercept_d   = 1'b0;
          rsp_rdata_d       = '0;
          bus_byte_enable_d = 4'b0000;
          bus_data_ctp_d    = '0;
          bus_read_d        = 1'b0;
          bus_write_d       = 1'b0;
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`endif
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      req_ready_q       <= 1'b1;
      rsp_valid_q       <= 1'b0;
      rsp_rdata_q       <= '0;
      rsp_fault_q       <= 1'b0;
      rsp_intercept_q   <= 1'b0;
      bus_address_q     <= '0;
      bus_byte_enable_q <= 4'b0000;
      bus_data_ctp_q    <= '0;
      bus_read_q        <= 1'b0;
      bus_write_q       <= 1'b0;
      write_q           <= 1'b0;
      unsigned_q        <= 1'b0;
      size_q            <= 2'd0;
      off_q             <= 2'd0;
`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
      cnt_q             <= '0;
`endif
    end else begin
      state_q           <= state_d;
      req_ready_q       <= req_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_rdata_q       <= rsp_rdata_d;
      rsp_fault_q       <= rsp_fault_d;
      rsp_intercept_q   <= rsp_intercept_d;
      bus_address_q     <= bus_address_d;
      bus_byte_enable_q <= bus_byte_enable_d;
      bus_data_ctp_q    <= bus_data_ctp_d;
      bus_read_q        <= bus_read_d;
      bus_write_q       <= bus_write_d;
      write_q           <= write_d;
      unsigned_q        <= unsigned_d;
      size_q            <= size_d;
      off_q             <= off_d;
`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
      cnt_q             <= cnt_d;
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_fault       = rsp_fault_q;
  assign rsp_intercept   = rsp_intercept_q;
  assign bus_address     = bus_address_q;
  assign bus_byte_enable = bus_byte_enable_q;
  assign bus_data_ctp    = bus_data_ctp_q;
  assign bus_read        = bus_read_q;
  assign bus_write       = bus_write_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_arilla_bus_master.sv
// Directed bench for arilla_bus_master: hand-computed vectors, expected read data queued per request.
module tb_arilla_bus_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_write, req_unsigned;
  logic [AW-1:0] req_address;
  logic [1:0]    req_size;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_fault, rsp_intercept;
  logic [DW-1:0] rsp_rdata;
  logic [AW-3:0] bus_address;
  logic [3:0]    bus_byte_enable;
  logic [DW-1:0] bus_data_ctp, bus_data_ptc;
  logic          bus_read, bus_write, bus_available, bus_hit, bus_intercept;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  arilla_bus_master #(.DataWidth(DW), .ByteAddressWidth(AW), .ByteSize(8), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rsp_intercept(rsp_intercept),
    .bus_address(bus_address), .bus_byte_enable(bus_byte_enable), .bus_data_ctp(bus_data_ctp),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_ptc(bus_data_ptc),
    .bus_available(bus_available), .bus_hit(bus_hit), .bus_intercept(bus_intercept),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [1:0] size, input logic uns, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] ptc, input logic hit, input logic icpt,
                        input int stall, input logic falign, input logic [3:0] exp_be,
                        input logic [DW-1:0] exp_ctp, input logic [AW-3:0] exp_addr,
                        input logic exp_fault, input logic exp_icpt, input logic [DW-1:0] exp_rdata);
    int k;
    bit seen;
    logic [DW-1:0] exp_r;
    exp_q.push_back(exp_rdata);
    req_valid     = 1'b1;
    req_write     = wr;
    req_address   = addr;
    req_size      = size;
    req_unsigned  = uns;
    req_wdata     = wdata;
    bus_data_ptc  = ptc;
    bus_hit       = hit;
    bus_intercept = icpt;
    bus_available = (stall == 0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      tick();
      k++;
      if (k == 1) begin
        req_valid = 1'b0;
        check({name, ":ready_low"}, 32'(req_ready), 32'd0);
        check({name, ":addr"}, 32'(bus_address), 32'(exp_addr));
        if (falign) begin
          check({name, ":no_strobe"}, 32'(bus_read | bus_write), 32'd0);
          check({name, ":no_be"}, 32'(bus_byte_enable), 32'd0);
        end else begin
          check({name, ":read"}, 32'(bus_read), 32'(!wr));
          check({name, ":write"}, 32'(bus_write), 32'(wr));
          check({name, ":be"}, 32'(bus_byte_enable), 32'(exp_be));
          check({name, ":ctp"}, bus_data_ctp, exp_ctp);
        end
      end else if (!falign && k <= 1 + stall) begin
        check({name, ":strobe_held"}, 32'(bus_read | bus_write), 32'd1);
        check({name, ":be_held"}, 32'(bus_byte_enable), 32'(exp_be));
        check({name, ":ctp_held"}, bus_data_ctp, exp_ctp);
      end
      if (k == 1 + stall) bus_available = 1'b1;
      if (rsp_valid) seen = 1'b1;
    end
    check({name, ":rsp_seen"}, 32'(seen), 32'd1);
    exp_r = exp_q.pop_front();
    if (seen) begin
      check({name, ":latency"}, 32'(k), falign ? 32'd1 : 32'(2 + stall));
      check({name, ":fault"}, 32'(rsp_fault), 32'(exp_fault));
      check({name, ":icpt"}, 32'(rsp_intercept), 32'(exp_icpt));
      check({name, ":rdata"}, rsp_rdata, exp_r);
      check({name, ":strobe_off"}, 32'(bus_read | bus_write), 32'd0);
      check({name, ":be_off"}, 32'(bus_byte_enable), 32'd0);
      tick();
      check({name, ":rsp_one"}, 32'(rsp_valid), 32'd0);
      check({name, ":ready_back"}, 32'(req_ready), 32'd1);
      check({name, ":idle"}, 32'(dbg_state), 32'd0);
    end
    bus_available = 1'b1;
    bus_hit       = 1'b1;
    bus_intercept = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = '0; bus_data_ptc = '0;
    bus_available = 1'b1; bus_hit = 1'b1; bus_intercept = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:ready", 32'(req_ready), 32'd1);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:rdata", rsp_rdata, 32'd0);
    check("rst:fault", 32'(rsp_fault), 32'd0);
    check("rst:icpt", 32'(rsp_intercept), 32'd0);
    check("rst:addr", 32'(bus_address), 32'd0);
    check("rst:be", 32'(bus_byte_enable), 32'd0);
    check("rst:ctp", bus_data_ctp, 32'd0);
    check("rst:strobes", 32'({bus_read, bus_write}), 32'd0);
    check("rst:state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    //      name         wr  addr         sz uns wdata         ptc           hit icpt st fal be       ctp           addr    flt ic rdata
    do_req("ldb_s",     0, 32'h1003, 0, 0, 32'h0,        32'h80FF0000, 1, 0, 0, 0, 4'b1000, 32'h0,        30'h400, 0, 0, 32'hFFFFFF80);
    do_req("sth",       1, 32'h22,   1, 0, 32'h1234ABCD, 32'h0,        1, 0, 3, 0, 4'b1100, 32'hABCDABCD, 30'h8,   0, 0, 32'h0);
    do_req("ldw_mis",   0, 32'h5,    2, 0, 32'h0,        32'hFFFFFFFF, 1, 0, 0, 1, 4'b0000, 32'h0,        30'h8,   1, 0, 32'h0);
    do_req("ldw_nohit", 0, 32'h40,   2, 0, 32'h0,        32'h11111111, 0, 1, 0, 0, 4'b1111, 32'h0,        30'h10,  1, 1, 32'h0);
    do_req("ldh_u",     0, 32'h102,  1, 1, 32'h0,        32'h80017FFF, 1, 0, 0, 0, 4'b1100, 32'h0,        30'h40,  0, 0, 32'h00008001);
    do_req("ldh_s",     0, 32'h0,    1, 0, 32'h0,        32'h1234F00D, 1, 0, 1, 0, 4'b0011, 32'h0,        30'h0,   0, 0, 32'hFFFFF00D);
    do_req("ldb_u",     0, 32'h1,    0, 1, 32'h0,        32'h0000A500, 1, 0, 0, 0, 4'b0010, 32'h0,        30'h0,   0, 0, 32'h000000A5);
    do_req("stb",       1, 32'h7,    0, 0, 32'hDEADBE5A, 32'h0,        1, 0, 0, 0, 4'b1000, 32'h5A5A5A5A, 30'h1,   0, 0, 32'h0);
    do_req("stw_icpt",  1, 32'h10,   2, 0, 32'hCAFEF00D, 32'h0,        1, 1, 2, 0, 4'b1111, 32'hCAFEF00D, 30'h4,   0, 1, 32'h0);
    do_req("ill_size",  0, 32'h0,    3, 0, 32'h0,        32'h0,        1, 0, 0, 1, 4'b0000, 32'h0,        30'h4,   1, 0, 32'h0);
    do_req("ldh_mis",   0, 32'h3,    1, 0, 32'h0,        32'h0,        1, 0, 0, 1, 4'b0000, 32'h0,        30'h4,   1, 0, 32'h0);
    do_req("ldw",       0, 32'hC,    2, 0, 32'h0,        32'h87654321, 1, 0, 0, 0, 4'b1111, 32'h0,        30'h3,   0, 0, 32'h87654321);
    do_req("ldw_late",  0, 32'h30,   2, 0, 32'h0,        32'h0BADF00D, 1, 0, 3, 0, 4'b1111, 32'h0,        30'hC,   0, 0, 32'h0BADF00D);

    // reset while a read is stalled on the bus
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h20; req_size = 2'd2;
    bus_available = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mid_rst:read_before", 32'(bus_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst:read_async", 32'(bus_read), 32'd0);
    check("mid_rst:ready_async", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus_available = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst:no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("mid_rst:ready", 32'(req_ready), 32'd1);
    check("mid_rst:idle", 32'(dbg_state), 32'd0);
    do_req("after_rst", 0, 32'h44, 2, 0, 32'h0, 32'h13579BDF, 1, 0, 0, 0, 4'b1111, 32'h0, 30'h11, 0, 0, 32'h13579BDF);

`ifdef ARILLA_BUS_MASTER_TIMEOUT_EN
    // bus never answers: strobe for TO cycles, then an aborted faulted response
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h30; req_size = 2'd2;
    bus_available = 1'b0; bus_data_ptc = 32'hFFFFFFFF;
    for (int k = 1; k <= TO + 1; k++) begin
      tick();
      req_valid = 1'b0;
      if (k <= TO) begin
        check("tmo:strobe", 32'(bus_read), 32'd1);
        check("tmo:no_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("tmo:rsp", 32'(rsp_valid), 32'd1);
        check("tmo:fault", 32'(rsp_fault), 32'd1);
        check("tmo:rdata", rsp_rdata, 32'd0);
        check("tmo:strobe_off", 32'(bus_read), 32'd0);
      end
    end
    tick();
    bus_available = 1'b1;
    check("tmo:ready", 32'(req_ready), 32'd1);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
